// File: rtl/time_pkg.sv
// time_pkg: shared field codes, slice positions, FSM states and field limits for the time-set writer.
package time_pkg;
  localparam logic [1:0] SEL_HOUR = 2'b00;
  localparam logic [1:0] SEL_MIN = 2'b01;
  localparam logic [1:0] SEL_SEC = 2'b11;
  localparam int HOUR_LSB = 14;
  localparam int MIN_LSB = 7;
  localparam int SEC_LSB = 0;
  localparam int DEF_HOUR_MAX = 23;
  localparam int DEF_MINSEC_MAX = 59;
  typedef enum logic [2:0] {IDLE, LOAD, EDIT, SETUP, STROBE, HOLD} state_t;
  function automatic logic [1:0] next_field(input logic [1:0] f);
    return f == SEL_HOUR ? SEL_MIN : SEL_SEC;
  endfunction
  function automatic logic [6:0] field_slice(input logic [20:0] t, input logic [1:0] f);
    return f == SEL_HOUR ? t[HOUR_LSB+:7] : f == SEL_MIN ? t[MIN_LSB+:7] : t[SEC_LSB+:7];
  endfunction
endpackage

// File: rtl/time_field_step.sv
// time_field_step: wrap-around +/-1 of a field value; simultaneous up and down cancel out.
module time_field_step (
  input  logic [6:0] value_i,
  input  logic [6:0] limit_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [6:0] next_o
);
  always_comb
    next_o = (up_i & ~down_i) ? (value_i == limit_i ? 7'd0 : value_i + 7'd1) :
             (down_i & ~up_i) ? (value_i == 7'd0 ? limit_i : value_i - 7'd1) : value_i;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven edit session over hh:mm:ss that commits each confirmed field
// to the time register through a setup / IE pulse / hold sequence.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int IE_PULSE   = 2,
  parameter int TIMEOUT    = 50_000_000,
  parameter int HOUR_MAX   = DEF_HOUR_MAX,
  parameter int MINSEC_MAX = DEF_MINSEC_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_ok,
  input  logic [20:0] t_cur,
  output logic        IE,
  output logic        enSet,
  output logic [1:0]  select,
  output logic [6:0]  D,
  output logic        editing,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(IE_PULSE + 1);
  state_t          state_q;
  logic [1:0]      field_q, sel_q;
  logic [TW-1:0]   tcnt_q;
  logic [SW-1:0]   scnt_q;
  logic [6:0]      d_q, d_d, limit, slice;
  logic            ie_q, en_q, editing_q, busy_q, last;
  assign limit = field_q == SEL_HOUR ? 7'(HOUR_MAX) : 7'(MINSEC_MAX);
  assign slice = field_slice(t_cur, field_q);
  assign last  = field_q == SEL_SEC;
  time_field_step u_step (
    .value_i(d_q),
    .limit_i(limit),
    .up_i   (btn_up),
    .down_i (btn_down),
    .next_o (d_d)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      field_q   <= SEL_HOUR;
      sel_q     <= SEL_HOUR;
      d_q       <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      ie_q      <= 1'b0;
      en_q      <= 1'b0;
      editing_q <= 1'b0;
      busy_q    <= 1'b0;
    end else
      case (state_q)
        IDLE: if (btn_mode) begin
          state_q <= LOAD;
          field_q <= SEL_HOUR;
        end
        LOAD: begin
          d_q       <= slice > limit ? limit : slice;
          sel_q     <= field_q;
          tcnt_q    <= '0;
          editing_q <= 1'b1;
          state_q   <= EDIT;
        end
        EDIT:
          if (btn_ok) begin
            state_q   <= SETUP;
            editing_q <= 1'b0;
            busy_q    <= 1'b1;
            en_q      <= 1'b1;
            tcnt_q    <= '0;
          end else if (btn_mode) begin
            editing_q <= 1'b0;
            tcnt_q    <= '0;
            field_q   <= next_field(field_q);
            state_q   <= last ? IDLE : LOAD;
          end else if (btn_up | btn_down) begin
            d_q    <= d_d;
            tcnt_q <= '0;
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            editing_q <= 1'b0;
            tcnt_q    <= '0;
            state_q   <= IDLE;
          end else tcnt_q <= tcnt_q + 1'b1;
        SETUP: begin
          ie_q    <= 1'b1;
          scnt_q  <= '0;
          state_q <= STROBE;
        end
        STROBE:
          if (scnt_q == SW'(IE_PULSE - 1)) begin
            ie_q    <= 1'b0;
            state_q <= HOLD;
          end else scnt_q <= scnt_q + 1'b1;
        HOLD: begin
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          field_q <= next_field(field_q);
          state_q <= last ? IDLE : LOAD;
        end
        default: state_q <= IDLE;
      endcase
  assign IE      = ie_q;
  assign enSet   = en_q;
  assign select  = sel_q;
  assign D       = d_q;
  assign editing = editing_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed self-checking bench for the time-set writer (TIMEOUT shortened to 8).
module tb_time_set_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_mode = 0, btn_up = 0, btn_down = 0, btn_ok = 0;
  logic [20:0] t_cur = '0;
  logic IE, enSet, editing, busy;
  logic [1:0] select;
  logic [6:0] D;
  int n_chk = 0, n_fail = 0, rises = 0;
  time_set_ctrl #(.IE_PULSE(2), .TIMEOUT(8), .HOUR_MAX(23), .MINSEC_MAX(59)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_ok(btn_ok), .t_cur(t_cur), .IE(IE), .enSet(enSet), .select(select), .D(D),
    .editing(editing), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge IE) rises++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic m, input logic u, input logic d, input logic o);
    btn_mode = m; btn_up = u; btn_down = d; btn_ok = o;
    @(negedge clk);
    btn_mode = 0; btn_up = 0; btn_down = 0; btn_ok = 0;
  endtask
  initial begin
    tick(2);
    chk("rst_ie", IE, 0);
    chk("rst_en", enSet, 0);
    chk("rst_sel", select, 0);
    chk("rst_d", D, 0);
    chk("rst_edit", editing, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    t_cur = {7'd10, 7'd30, 7'd45};
    pulse(0, 1, 0, 1);
    chk("idle_ignore", editing, 0);
    pulse(1, 0, 0, 0);
    tick();
    chk("load_edit", editing, 1);
    chk("load_sel", select, 2'b00);
    chk("load_d", D, 10);
    chk("load_ie", IE, 0);
    chk("load_en", enSet, 0);
    for (int i = 0; i < 14; i++) pulse(0, 1, 0, 0);
    chk("hour_wrap_up", D, 0);
    pulse(0, 0, 1, 0);
    chk("hour_wrap_down", D, 23);
    pulse(0, 0, 0, 1);
    chk("setup_en", enSet, 1);
    chk("setup_ie", IE, 0);
    chk("setup_busy", busy, 1);
    chk("setup_edit", editing, 0);
    btn_up = 1; btn_mode = 1;
    tick();
    chk("strobe1_ie", IE, 1);
    chk("strobe1_sel", select, 2'b00);
    chk("strobe1_d", D, 23);
    tick();
    chk("strobe2_ie", IE, 1);
    btn_up = 0; btn_mode = 0;
    tick();
    chk("hold_ie", IE, 0);
    chk("hold_en", enSet, 1);
    chk("hold_d_busy_ignored", D, 23);
    tick();
    chk("after_hold_en", enSet, 0);
    tick();
    chk("min_sel", select, 2'b01);
    chk("min_d", D, 30);
    chk("hour_rises", rises, 1);
    pulse(0, 1, 1, 0);
    chk("updown_same", D, 30);
    for (int i = 0; i < 30; i++) pulse(0, 1, 0, 0);
    chk("min_zero", D, 0);
    pulse(0, 0, 1, 0);
    chk("min_wrap_down", D, 59);
    pulse(1, 0, 0, 0);
    chk("skip_en", enSet, 0);
    tick();
    chk("sec_sel", select, 2'b11);
    chk("sec_d", D, 45);
    chk("skip_no_rise", rises, 1);
    pulse(0, 1, 0, 1);
    chk("okup_d", D, 45);
    chk("okup_en", enSet, 1);
    tick(4);
    chk("sec_done_edit", editing, 0);
    chk("sec_done_busy", busy, 0);
    chk("sec_done_en", enSet, 0);
    chk("idle_hold_sel", select, 2'b11);
    chk("idle_hold_d", D, 45);
    chk("sec_rises", rises, 2);
    pulse(1, 0, 0, 0);
    tick();
    chk("to_edit", editing, 1);
    tick(7);
    chk("to_still_edit", editing, 1);
    pulse(0, 1, 0, 0);
    chk("to_restart_d", D, 11);
    tick(7);
    chk("to_restart_edit", editing, 1);
    tick();
    chk("to_expired", editing, 0);
    chk("to_d_kept", D, 11);
    chk("to_no_rise", rises, 2);
    pulse(1, 0, 0, 0);
    tick();
    pulse(0, 0, 0, 1);
    tick();
    chk("abort_ie_hi", IE, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ie", IE, 0);
    chk("abort_en", enSet, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_edit", editing, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_d", D, 0);
    chk("post_rst_sel", select, 0);
    t_cur = {7'd99, 7'd70, 7'd5};
    pulse(1, 0, 0, 0);
    tick();
    chk("clamp_hour", D, 23);
    pulse(1, 0, 0, 0);
    tick();
    chk("clamp_min", D, 59);
    chk("clamp_min_sel", select, 2'b01);
    pulse(1, 0, 0, 0);
    tick();
    chk("sec_5", D, 5);
    pulse(1, 0, 0, 0);
    chk("skip_last_idle", editing, 0);
    tick(2);
    chk("skip_last_stays", editing, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Writer side of the time-register set interface (IE, enSet, select, D).
- Turns debounced single-cycle button pulses into an edit session over hours, minutes and seconds.
- Preloads each field from the live time word and adjusts it with up/down wrap-around.
- Commits each confirmed field with a correctly sequenced IE strobe (setup, pulse, hold) so the time register captures it on IE's rising edge.

Parameters:
- IE_PULSE, 2, cycles IE is held high per commit (>=1)
- TIMEOUT, 50_000_000, idle cycles in EDIT before the session is abandoned
- HOUR_MAX, 23, upper limit of the hours field
- MINSEC_MAX, 59, upper limit of the minutes and seconds fields

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  1-cycle pulse: start session / skip field
- btn_up  in  1  1-cycle pulse: increment field
- btn_down  in  1  1-cycle pulse: decrement field
- btn_ok  in  1  1-cycle pulse: commit field
- t_cur  in  21  live time word: [20:14] hours, [13:7] minutes, [6:0] seconds, binary
- IE  out  1  write strobe; target captures on its rising edge
- enSet  out  1  write enable, qualifies IE
- select  out  2  field code: 00 hours, 01 minutes, 11 seconds (10 never driven)
- D  out  7  field value being edited or written
- editing  out  1  high in EDIT
- busy  out  1  high in SETUP/STROBE/HOLD

Behaviour:
- Reset (async, rst_n=0): state=IDLE, IE=0, enSet=0, select=00, D=0, editing=0, busy=0, field=hours, timeout counter=0.
- Reset asserted mid-operation: all outputs return to reset values immediately; any in-flight strobe is aborted with IE low.
- Field order: hours(00) -> minutes(01) -> seconds(11) -> back to IDLE.
- The field limit is HOUR_MAX for hours, MINSEC_MAX otherwise.
- IDLE:
  - btn_mode -> LOAD; field=hours.
  - All other buttons are ignored.
- LOAD (1 cycle):
  - D <= t_cur slice for the current field, clamped to the field limit if larger.
  - select <= field code.
  - Next state EDIT.
- EDIT (editing=1):
  - btn_up: D = (D==limit) ? 0 : D+1.
  - btn_down: D = (D==0) ? limit : D-1.
  - btn_ok: go to SETUP.
  - btn_mode: skip the field with no write. Advance to the next field and go to LOAD; after seconds, go to IDLE.
- EDIT button priority:
  - ok > mode > up/down.
  - up and down in the same cycle: no change.
  - Every accepted button clears the timeout counter.
- EDIT timeout: the counter reaching TIMEOUT-1 with no button -> IDLE, no write, D unchanged.
- SETUP (1 cycle): enSet=1, IE=0; select and D stable.
- STROBE (IE_PULSE cycles): IE=1, enSet=1; select and D stable.
- HOLD (1 cycle): IE=0, enSet=1; select and D stable. Then advance the field: LOAD for the next field, or IDLE after seconds.
- busy=1 in SETUP/STROBE/HOLD. All buttons are ignored while busy.
- enSet=0 in every state except SETUP/STROBE/HOLD.
- IE is registered, glitch-free, and rises exactly once per commit.
- select and D never change while enSet=1.
- In IDLE, select and D hold their last values.
- Outputs are registered; button-to-D update latency is 1 cycle.

Decomposition:
- Shared package (time_pkg):
  - field codes SEL_HOUR=2'b00, SEL_MIN=2'b01, SEL_SEC=2'b11
  - field slice positions
  - state enum {IDLE, LOAD, EDIT, SETUP, STROBE, HOLD}
  - HOUR_MAX and MINSEC_MAX defaults
- One sub-module: time_field_step. Combinational wrap-around +/-1 with inputs value, limit, up, down.
- FSM, timeout counter and strobe counter stay in the top level.

Test Plan:
- Reset, then btn_mode with t_cur={7'd10,7'd30,7'd45} -> after 2 cycles editing=1, select=00, D=10; IE=0, enSet=0.
- In hours: btn_up x14 from 10 -> D=0 (wraps after 23). btn_down -> D=23. btn_ok -> SETUP 1 cycle, IE high for exactly 2 cycles with select=00, D=23, enSet=1. HOLD 1 cycle, then select=01, D=30.
- Minutes D=0: btn_down -> D=59. btn_mode -> no IE pulse, select=11, D=45. btn_ok -> one IE pulse with D=45, then IDLE, editing=0.
- Same-cycle conflicts:
  - btn_up+btn_down in EDIT -> D unchanged.
  - btn_ok+btn_up -> write of the pre-increment value.
  - Buttons during busy -> ignored.
- TIMEOUT=8: enter EDIT, no buttons for 8 cycles -> IDLE with no IE edge; a button at cycle 7 restarts the count.
- rst_n low during STROBE -> IE and enSet fall immediately; after release, IDLE with all outputs at reset values.
